sprite_line_render: RTL and testbench
=====================================

Name: sprite_line_render

Overview:
Consumer side of the per-line sprite selection buffer. Once the buffer for the current line is marked prepared, this block walks the selected-sprite list and fetches each sprite's OAM entry and pixel row. It writes the opaque pixels into the scanline buffer that feeds the video output. It sits between the line-preparation stage, OAM, sprite pattern memory and the line buffer.

Parameters:
MAX_OBJ_PER_LINE, 32, number of entries in the selected-sprite list
OAM_ADDR_SIZE, 6, width of an OAM entry index
LINE_WIDTH, 640, visible pixels per line; writes at or beyond this column are suppressed

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
buffer_array  in  MAX_OBJ_PER_LINE x (OAM_ADDR_SIZE+1)  selected-sprite list; entry bit0 = valid, bits OAM_ADDR_SIZE:1 = OAM index
line_prepared  in  1  high while buffer_array is complete and stable for the current line
sy  in  10  current line number
oam_addr  out  OAM_ADDR_SIZE  OAM read address; 1-cycle read latency
oam_data  in  32  [31] enable, [30] y-flip, [29] x-flip, [28] priority, [27:18] y, [17:8] x, [7:0] sprite ref
sprite_addr  out  12  pattern memory row address = {sprite ref, row[3:0]}; 1-cycle read latency
sprite_data  in  64  16 pixels x 4 bit; pixel p is at [4p+3:4p], p=0 is leftmost
lb_we  out  1  line buffer write strobe
lb_addr  out  10  line buffer column
lb_data  out  5  {priority, pixel[3:0]}
line_done  out  1  all entries rendered for this line

Behaviour:
- Reset: state IDLE. All outputs are 0: oam_addr, sprite_addr, lb_we, lb_addr, lb_data, line_done. The entry index idx = MAX_OBJ_PER_LINE-1.
- Start condition: IDLE sees a 0->1 edge on line_prepared (registered copy). Next state SCAN with idx = MAX_OBJ_PER_LINE-1.
- Processing order is descending idx. Lower-index sprites are drawn later and overwrite higher ones, so entry 0 has the highest priority.
- SCAN (1 cycle):
  - If buffer_array[idx].valid: oam_addr <= entry OAM index; go OAM_WAIT.
  - Otherwise: if idx==0 go DONE, else idx-- and stay in SCAN.
- OAM_WAIT (1 cycle):
  - oam_data is valid this cycle. Latch x, priority, x-flip, sprite ref.
  - row = (sy - y) mod 16, 4 LSBs of the 10-bit difference. With y-flip, row = 15 - row.
  - sprite_addr <= {ref, row}; go ROW_WAIT.
  - If oam enable = 0: skip the sprite, using the same advance as the end of DRAW.
- ROW_WAIT (1 cycle): latch sprite_data; col = 0; go DRAW.
- DRAW (exactly 16 cycles, col 0..15):
  - Source pixel p = xflip ? 15-col : col.
  - Target column = x + col, computed 11 bits wide.
  - lb_we = 1 only if pixel != 0 and the target column < LINE_WIDTH. Pixel value 0 is transparent.
  - lb_addr = target[9:0]; lb_data = {priority, pixel}. lb_we, lb_addr and lb_data are registered together in the same cycle.
  - After col 15: if idx==0 go DONE, else idx-- and go SCAN.
- Cycle costs:
  - Valid, enabled entry: 19 cycles.
  - Invalid entry: 1 cycle.
  - Disabled OAM entry: 2 cycles.
  - Worst case 32 x 19 = 608 cycles per line.
- DONE: line_done = 1, held until line_prepared = 0; then go IDLE with line_done = 0.
- Abort: line_prepared = 0 in any state other than IDLE. Next cycle is IDLE, lb_we = 0 and line_done = 0. No further writes for that line.
- Reset mid-operation: takes precedence over everything and returns the block to reset values in the next cycle.
- lb_we is never asserted outside DRAW.
- buffer_array is sampled live. It must stay stable while line_prepared = 1.

Test Plan:
- Single sprite: entry0 = {idx 3, valid}; OAM[3] = enable, y=100, x=200, ref=5; sy=103; all pixels = 4'h7 -> sprite_addr = {8'd5, 4'd3}; 16 writes to lb_addr 200..215 with data 5'h07; line_done 19 cycles after SCAN starts, plus the invalid-entry SCAN cycles.
- Flips and transparency: x-flip=1, y-flip=1, sy-y=2, pixel0=4'hA, others 0 -> sprite_addr row = 13; exactly one write, at x+15 with data 4'hA.
- Priority ordering: entries 0 and 1 both at x=10, opaque, priority bits differ -> entry 1's writes occur before entry 0's; the last write to column 10 carries entry 0's data.
- Right edge clip: x=630 -> writes only for columns 630..639 (10 writes); no write wraps to a low column.
- Empty list: all entries invalid -> no lb_we; line_done = 1 after 32 SCAN cycles; drop line_prepared -> line_done = 0 next cycle.
- Abort and reset: deassert line_prepared during DRAW -> lb_we = 0 next cycle, state IDLE. Assert reset mid-DRAW -> all outputs 0 next cycle; a new line_prepared rising edge restarts from idx 31.

Source files
------------

// File: rtl/sprite_line_render_if.sv
// Bundle of the selected-sprite list, OAM / pattern memory read ports and line buffer write port
// as seen by the sprite line renderer (master) and its environment (slave).
interface sprite_line_render_if #(
    parameter int unsigned MAX_OBJ_PER_LINE = 32,
    parameter int unsigned OAM_ADDR_SIZE    = 6
);
    logic [MAX_OBJ_PER_LINE-1:0][OAM_ADDR_SIZE:0] buffer_array;
    logic                                         line_prepared;
    logic [9:0]                                   sy;
    logic [OAM_ADDR_SIZE-1:0]                     oam_addr;
    logic [31:0]                                  oam_data;
    logic [11:0]                                  sprite_addr;
    logic [63:0]                                  sprite_data;
    logic                                         lb_we;
    logic [9:0]                                   lb_addr;
    logic [4:0]                                   lb_data;
    logic                                         line_done;

    modport master (
        input  buffer_array, line_prepared, sy, oam_data, sprite_data,
        output oam_addr, sprite_addr, lb_we, lb_addr, lb_data, line_done
    );

    modport slave (
        output buffer_array, line_prepared, sy, oam_data, sprite_data,
        input  oam_addr, sprite_addr, lb_we, lb_addr, lb_data, line_done
    );
endinterface

// File: rtl/sprite_line_render.sv
// Walks the per-line selected-sprite list from the highest index down, fetches OAM entry and
// pattern row for each valid sprite and writes its opaque, on-screen pixels into the line buffer.
module sprite_line_render #(
    parameter int unsigned MAX_OBJ_PER_LINE = 32,
    parameter int unsigned OAM_ADDR_SIZE    = 6,
    parameter int unsigned LINE_WIDTH       = 640
) (
    input  logic                 clk,
    input  logic                 reset,
    sprite_line_render_if.master bus_io
);
    localparam int unsigned     IdxW      = (MAX_OBJ_PER_LINE > 1) ? $clog2(MAX_OBJ_PER_LINE) : 1;
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(MAX_OBJ_PER_LINE - 1);
    localparam logic [10:0]     LineWidth = 11'(LINE_WIDTH);

    typedef enum logic [2:0] {
        StIdle, StScan, StOamWait, StRowWait, StDraw, StDone
    } state_e;

    state_e                   state_q;
    logic [IdxW-1:0]          idx_q;
    logic                     prep_q;
    logic [3:0]               col_q;
    logic [9:0]               x_q;
    logic                     pri_q;
    logic                     xflip_q;
    logic [63:0]              pix_q;
    logic [OAM_ADDR_SIZE-1:0] oam_addr_q;
    logic [11:0]              sprite_addr_q;
    logic                     lb_we_q;
    logic [9:0]               lb_addr_q;
    logic [4:0]               lb_data_q;
    logic                     line_done_q;

    logic [OAM_ADDR_SIZE:0] entry;
    logic [9:0]             dy;
    logic [3:0]             row;
    logic                   last_entry;

    assign entry      = bus_io.buffer_array[idx_q];
    assign dy         = bus_io.sy - bus_io.oam_data[27:18];
    assign row        = dy[3:0] ^ {4{bus_io.oam_data[30]}};
    assign last_entry = (idx_q == '0);

    // Line buffer outputs run one column ahead: ROW_WAIT prepares column 0 from the live pattern
    // data, so each DRAW cycle shows the write for its own column.
    logic [3:0]  draw_col;
    logic [3:0]  src_p;
    logic [63:0] draw_src;
    logic [3:0]  draw_pix;
    logic [10:0] draw_tgt;
    logic        draw_we;

    always_comb begin
        draw_col = (state_q == StRowWait) ? 4'd0 : col_q + 4'd1;
        draw_src = (state_q == StRowWait) ? bus_io.sprite_data : pix_q;
        src_p    = xflip_q ? ~draw_col : draw_col;
        draw_pix = draw_src[{src_p, 2'b00} +: 4];
        draw_tgt = {1'b0, x_q} + {7'd0, draw_col};
        draw_we  = (draw_pix != 4'd0) && (draw_tgt < LineWidth);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            idx_q         <= IdxLast;
            prep_q        <= 1'b0;
            col_q         <= 4'd0;
            x_q           <= 10'd0;
            pri_q         <= 1'b0;
            xflip_q       <= 1'b0;
            pix_q         <= 64'd0;
            oam_addr_q    <= '0;
            sprite_addr_q <= 12'd0;
            lb_we_q       <= 1'b0;
            lb_addr_q     <= 10'd0;
            lb_data_q     <= 5'd0;
            line_done_q   <= 1'b0;
        end else begin
            prep_q  <= bus_io.line_prepared;
            lb_we_q <= 1'b0;
            if (state_q != StIdle && !bus_io.line_prepared) begin
                state_q     <= StIdle;
                line_done_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (bus_io.line_prepared && !prep_q) begin
                            state_q <= StScan;
                            idx_q   <= IdxLast;
                        end
                    end
                    StScan: begin
                        if (entry[0]) begin
                            oam_addr_q <= entry[OAM_ADDR_SIZE:1];
                            state_q    <= StOamWait;
                        end else if (last_entry) begin
                            state_q     <= StDone;
                            line_done_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q - 1'b1;
                        end
                    end
                    StOamWait: begin
                        x_q           <= bus_io.oam_data[17:8];
                        pri_q         <= bus_io.oam_data[28];
                        xflip_q       <= bus_io.oam_data[29];
                        sprite_addr_q <= {bus_io.oam_data[7:0], row};
                        if (bus_io.oam_data[31]) begin
                            state_q <= StRowWait;
                        end else if (last_entry) begin
                            state_q     <= StDone;
                            line_done_q <= 1'b1;
                        end else begin
                            idx_q   <= idx_q - 1'b1;
                            state_q <= StScan;
                        end
                    end
                    StRowWait: begin
                        pix_q     <= bus_io.sprite_data;
                        col_q     <= 4'd0;
                        state_q   <= StDraw;
                        lb_we_q   <= draw_we;
                        lb_addr_q <= draw_tgt[9:0];
                        lb_data_q <= {pri_q, draw_pix};
                    end
                    StDraw: begin
                        if (col_q == 4'd15) begin
                            if (last_entry) begin
                                state_q     <= StDone;
                                line_done_q <= 1'b1;
                            end else begin
                                idx_q   <= idx_q - 1'b1;
                                state_q <= StScan;
                            end
                        end else begin
                            col_q     <= col_q + 4'd1;
                            lb_we_q   <= draw_we;
                            lb_addr_q <= draw_tgt[9:0];
                            lb_data_q <= {pri_q, draw_pix};
                        end
                    end
                    StDone: begin
                        line_done_q <= 1'b1;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus_io.oam_addr    = oam_addr_q;
    assign bus_io.sprite_addr = sprite_addr_q;
    assign bus_io.lb_we       = lb_we_q;
    assign bus_io.lb_addr     = lb_addr_q;
    assign bus_io.lb_data     = lb_data_q;
    assign bus_io.line_done   = line_done_q;
endmodule

// File: tb/tb_sprite_line_render.sv
// Bench for sprite_line_render: directed scenarios plus random lines, checked against a
// list-walking reference model of the expected line buffer writes and line timing.
module tb_sprite_line_render;
    logic clk = 1'b0;
    logic reset;

    sprite_line_render_if bus_if ();

    sprite_line_render dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus_if)
    );

    always #5 clk = ~clk;

    logic [31:0] oam_mem [64];
    logic [63:0] pat_mem [4096];

    assign bus_if.oam_data    = oam_mem[bus_if.oam_addr];
    assign bus_if.sprite_data = pat_mem[bus_if.sprite_addr];

    logic [14:0] wr_q [$];
    logic [14:0] exp_q [$];
    int n_assert = 0;
    int n_fail   = 0;

    always @(negedge clk) begin
        if (bus_if.lb_we === 1'b1) wr_q.push_back({bus_if.lb_addr, bus_if.lb_data});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walk the list from entry 31 down to 0; later writes overwrite earlier ones.
    task automatic build_model(output int cost);
        logic [31:0] e;
        logic [63:0] d;
        int row, p, pix, tgt;
        exp_q.delete();
        cost = 0;
        for (int i = 31; i >= 0; i--) begin
            if (bus_if.buffer_array[i][0] == 1'b0) begin
                cost += 1;
            end else begin
                e = oam_mem[bus_if.buffer_array[i][6:1]];
                if (!e[31]) begin
                    cost += 2;
                end else begin
                    cost += 19;
                    row = (int'(bus_if.sy) - int'(e[27:18])) & 15;
                    if (e[30]) row = 15 - row;
                    d = pat_mem[{e[7:0], 4'(row)}];
                    for (int c = 0; c < 16; c++) begin
                        p   = e[29] ? 15 - c : c;
                        pix = int'((d >> (4 * p)) & 64'hF);
                        tgt = int'(e[17:8]) + c;
                        if (pix != 0 && tgt < 640) exp_q.push_back({10'(tgt), e[28], 4'(pix)});
                    end
                end
            end
        end
    endtask

    task automatic run_line(input string tag);
        int cost, k, n;
        build_model(cost);
        wr_q.delete();
        bus_if.line_prepared = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus_if.line_done !== 1'b1 && k < 800);
        check({tag, " done cycle"}, 64'(k), 64'(1 + cost));
        check({tag, " write count"}, 64'(wr_q.size()), 64'(exp_q.size()));
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, " write"}, 64'(wr_q[i]), 64'(exp_q[i]));
        bus_if.line_prepared = 1'b0;
        @(negedge clk);
        check({tag, " done drop"}, 64'(bus_if.line_done), 64'd0);
        @(negedge clk);
    endtask

    task automatic clear_list();
        for (int i = 0; i < 32; i++) bus_if.buffer_array[i] = '0;
    endtask

    task automatic wait_write(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus_if.lb_we !== 1'b1 && k < 800);
        check({tag, " reached draw"}, 64'(bus_if.lb_we), 64'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " oam_addr"}, 64'(bus_if.oam_addr), 64'd0);
        check({tag, " sprite_addr"}, 64'(bus_if.sprite_addr), 64'd0);
        check({tag, " lb_we"}, 64'(bus_if.lb_we), 64'd0);
        check({tag, " lb_addr"}, 64'(bus_if.lb_addr), 64'd0);
        check({tag, " lb_data"}, 64'(bus_if.lb_data), 64'd0);
        check({tag, " line_done"}, 64'(bus_if.line_done), 64'd0);
    endtask

    function automatic logic [63:0] rand_row();
        logic [63:0] r;
        for (int p = 0; p < 16; p++)
            r[4*p +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        return r;
    endfunction

    initial begin
        int n, last;
        reset = 1'b1;
        bus_if.line_prepared = 1'b0;
        bus_if.sy = 10'd0;
        clear_list();
        for (int i = 0; i < 64; i++) oam_mem[i] = 32'd0;
        for (int i = 0; i < 4096; i++) pat_mem[i] = rand_row();
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single sprite, plain orientation.
        oam_mem[3] = {1'b1, 1'b0, 1'b0, 1'b0, 10'd100, 10'd200, 8'd5};
        pat_mem[{8'd5, 4'd3}] = {16{4'h7}};
        bus_if.buffer_array[0] = {6'd3, 1'b1};
        bus_if.sy = 10'd103;
        run_line("single");
        check("single sprite_addr", 64'(bus_if.sprite_addr), 64'h053);
        check("single first write", (wr_q.size() > 0) ? 64'(wr_q[0]) : 64'h7FFF, {10'd200, 5'h07});

        // Both flips, one opaque pixel.
        oam_mem[3] = {1'b1, 1'b1, 1'b1, 1'b0, 10'd100, 10'd300, 8'd6};
        pat_mem[{8'd6, 4'd13}] = 64'hA;
        bus_if.sy = 10'd102;
        run_line("flip");
        check("flip sprite_addr", 64'(bus_if.sprite_addr), 64'h06D);
        check("flip writes", 64'(wr_q.size()), 64'd1);
        check("flip write", (wr_q.size() > 0) ? 64'(wr_q[0]) : 64'h7FFF, {10'd315, 5'h0A});

        // Two overlapping sprites: entry 0 must land last.
        oam_mem[1] = {1'b1, 1'b0, 1'b0, 1'b1, 10'd50, 10'd10, 8'd20};
        oam_mem[2] = {1'b1, 1'b0, 1'b0, 1'b0, 10'd50, 10'd10, 8'd21};
        pat_mem[{8'd20, 4'd0}] = {16{4'h3}};
        pat_mem[{8'd21, 4'd0}] = {16{4'h5}};
        bus_if.buffer_array[0] = {6'd1, 1'b1};
        bus_if.buffer_array[1] = {6'd2, 1'b1};
        bus_if.sy = 10'd50;
        run_line("prio");
        last = -1;
        for (int i = 0; i < wr_q.size(); i++) if (wr_q[i][14:5] == 10'd10) last = i;
        check("prio last col10", (last >= 0) ? 64'(wr_q[last][4:0]) : 64'h7F, 64'h13);
        check("prio first col10", (wr_q.size() > 0) ? 64'(wr_q[0]) : 64'h7FFF, {10'd10, 5'h05});

        // Right edge clip.
        clear_list();
        oam_mem[3] = {1'b1, 1'b0, 1'b0, 1'b0, 10'd100, 10'd630, 8'd5};
        bus_if.buffer_array[0] = {6'd3, 1'b1};
        bus_if.sy = 10'd103;
        run_line("clip");
        check("clip writes", 64'(wr_q.size()), 64'd10);
        n = 0;
        for (int i = 0; i < wr_q.size(); i++) if (wr_q[i][14:5] < 10'd630) n++;
        check("clip no wrap", 64'(n), 64'd0);

        // Empty list.
        clear_list();
        run_line("empty");
        check("empty writes", 64'(wr_q.size()), 64'd0);

        // Random lines.
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 32; i++)
                bus_if.buffer_array[i] = {6'($urandom_range(0, 63)), ($urandom_range(0, 2) == 0)};
            for (int i = 0; i < 64; i++) begin
                oam_mem[i] = $urandom;
                oam_mem[i][31] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 1) == 1) oam_mem[i][17:8] = 10'($urandom_range(600, 1023));
            end
            bus_if.sy = 10'($urandom);
            run_line("random");
        end

        // Abort mid-draw.
        clear_list();
        oam_mem[3] = {1'b1, 1'b0, 1'b0, 1'b0, 10'd100, 10'd200, 8'd5};
        bus_if.buffer_array[0] = {6'd3, 1'b1};
        bus_if.sy = 10'd103;
        wr_q.delete();
        bus_if.line_prepared = 1'b1;
        wait_write("abort");
        bus_if.line_prepared = 1'b0;
        @(negedge clk);
        check("abort lb_we", 64'(bus_if.lb_we), 64'd0);
        check("abort line_done", 64'(bus_if.line_done), 64'd0);
        n = wr_q.size();
        repeat (30) @(negedge clk);
        check("abort no more writes", 64'(wr_q.size()), 64'(n));
        check("abort stays idle", 64'(bus_if.line_done), 64'd0);

        // Reset mid-draw, then a fresh line from entry 31.
        bus_if.line_prepared = 1'b1;
        wait_write("rst");
        reset = 1'b1;
        bus_if.line_prepared = 1'b0;
        @(negedge clk);
        check_zero("rst mid");
        reset = 1'b0;
        @(negedge clk);
        run_line("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
